// File: rtl/tpic_chain_driver.sv
// Multi-chain serial driver for daisy-chained TPIC power shift registers.
// All chains share sclk/rck/en_n; each chain has its own serial data line.
module tpic_chain_driver #(
  parameter int WIDTH     = 16,
  parameter int CHAINS    = 1,
  parameter int HALF_PER  = 1,
  parameter int LSB_FIRST = 1,
  parameter int AUTO      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CHAINS*WIDTH-1:0]  data,
  input  logic                     oe,
  output logic                     sclk,
  output logic                     rck,
  output logic                     en_n,
  output logic [CHAINS-1:0]        sout,
  output logic                     busy,
  output logic                     done
);

  localparam int HW = $clog2(HALF_PER + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PER - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_LATCH} state_t;

  state_t                    state_q, state_d;
  logic [HW-1:0]             half_q, half_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [CHAINS*WIDTH-1:0]   sr_q, sr_d, shifted;
  logic [CHAINS-1:0]         sout_q, sout_d;
  logic                      sclk_q, sclk_d;
  logic                      rck_q, rck_d;
  logic                      en_n_q, en_n_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pending_q, pending_d;

  function automatic logic [CHAINS*WIDTH-1:0] shift_all(input logic [CHAINS*WIDTH-1:0] v);
    logic [CHAINS*WIDTH-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < CHAINS; c++) begin
      if (LSB_FIRST != 0) r[c*WIDTH +: WIDTH] = {1'b0, v[c*WIDTH+1 +: WIDTH-1]};
      else                r[c*WIDTH +: WIDTH] = {v[c*WIDTH +: WIDTH-1], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [CHAINS-1:0] first_bits(input logic [CHAINS*WIDTH-1:0] v);
    logic [CHAINS-1:0] b;
    b = '0;
    for (int unsigned c = 0; c < CHAINS; c++) begin
      if (LSB_FIRST != 0) b[c] = v[c*WIDTH];
      else                b[c] = v[c*WIDTH + WIDTH - 1];
    end
    return b;
  endfunction

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    sout_d    = sout_q;
    sclk_d    = sclk_q;
    rck_d     = rck_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pending_d = pending_q;
    en_n_d    = ~oe;
    shifted   = shift_all(sr_q);

    // A request arriving during a frame is remembered once and served after done.
    if (AUTO == 0 && start && state_q != S_IDLE) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start || pending_q || AUTO != 0) begin
          sr_d      = data;
          sout_d    = first_bits(data);
          bit_d     = '0;
          half_d    = '0;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          pending_d = 1'b0;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          sclk_d = 1'b0;
          if (bit_q < BIT_LAST) begin
            sr_d    = shifted;
            sout_d  = first_bits(shifted);
            bit_d   = bit_q + 1'b1;
            state_d = S_LOW;
          end else begin
            rck_d   = 1'b1;
            state_d = S_LATCH;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          rck_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      half_q    <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      sout_q    <= '0;
      sclk_q    <= 1'b0;
      rck_q     <= 1'b0;
      en_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      sout_q    <= sout_d;
      sclk_q    <= sclk_d;
      rck_q     <= rck_d;
      en_n_q    <= en_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
    end
  end

  assign sclk = sclk_q;
  assign rck  = rck_q;
  assign en_n = en_n_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tpic_chain_driver.sv
// Directed bench for tpic_chain_driver: LSB-first, MSB-first and free-running instances.
module tb_tpic_chain_driver;

  logic        clk = 1'b0;
  logic        reset, start, oe;
  logic [15:0] data, data_a;

  logic sclk_l, rck_l, en_n_l, busy_l, done_l; logic [1:0] sout_l;
  logic sclk_m, rck_m, en_n_m, busy_m, done_m; logic [1:0] sout_m;
  logic sclk_a, rck_a, en_n_a, busy_a, done_a; logic [0:0] sout_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tpic_chain_driver #(.WIDTH(8), .CHAINS(2), .HALF_PER(2), .LSB_FIRST(1), .AUTO(0)) u_lsb (
    .clk(clk), .reset(reset), .start(start), .data(data), .oe(oe),
    .sclk(sclk_l), .rck(rck_l), .en_n(en_n_l), .sout(sout_l), .busy(busy_l), .done(done_l));

  tpic_chain_driver #(.WIDTH(8), .CHAINS(2), .HALF_PER(2), .LSB_FIRST(0), .AUTO(0)) u_msb (
    .clk(clk), .reset(reset), .start(start), .data(data), .oe(oe),
    .sclk(sclk_m), .rck(rck_m), .en_n(en_n_m), .sout(sout_m), .busy(busy_m), .done(done_m));

  tpic_chain_driver #(.WIDTH(16), .CHAINS(1), .HALF_PER(1), .LSB_FIRST(1), .AUTO(1)) u_auto (
    .clk(clk), .reset(reset), .start(start), .data(data_a), .oe(oe),
    .sclk(sclk_a), .rck(rck_a), .en_n(en_n_a), .sout(sout_a), .busy(busy_a), .done(done_a));

  typedef struct {
    int rises, rcks, busy, dones, viol, gap, brise, run1, cyc, d1, d2;
    logic [15:0] w0, w1;
    logic ps, pr, pb;
  } mon_t;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  l0, l1, m0, m1;  // bit i = sout value at sclk rise i
  } vec_t;

  vec_t vecs[6];

  function automatic mon_t mon_new();
    mon_t m;
    m.rises = 0; m.rcks = 0; m.busy = 0; m.dones = 0; m.viol = 0; m.gap = 0;
    m.brise = 0; m.run1 = 0; m.cyc = 0; m.d1 = 0; m.d2 = 0;
    m.w0 = '0; m.w1 = '0; m.ps = 1'b0; m.pr = 1'b0; m.pb = 1'b0;
    return m;
  endfunction

  task automatic mon_step(input mon_t mi, input logic s, input logic r, input logic b,
                          input logic d, input logic [1:0] so, output mon_t mo);
    mo = mi;
    mo.cyc++;
    if (s && !mi.ps) begin
      if (mo.rises < 16) begin
        mo.w0[mo.rises[3:0]] = so[0];
        mo.w1[mo.rises[3:0]] = so[1];
      end
      mo.rises++;
    end
    if (r && !mi.pr) mo.rcks++;
    if (r && s) mo.viol++;
    if (b && !mi.pb) mo.brise++;
    if (b) mo.busy++;
    if (b && mo.brise == 1) mo.run1++;
    if (d) begin
      mo.dones++;
      if (mo.dones == 1) mo.d1 = mo.cyc;
      else if (mo.dones == 2) mo.d2 = mo.cyc;
    end
    if (!b && mo.brise == 1 && mo.dones >= 1) mo.gap++;
    mo.ps = s; mo.pr = r; mo.pb = b;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One start pulse; optionally three more starts plus a data change mid-frame.
  task automatic run_frame(input logic [15:0] d, input logic [15:0] d2, input bit inj,
                           input int cycles, output mon_t ml, output mon_t mm);
    ml = mon_new();
    mm = mon_new();
    @(negedge clk);
    data  = d;
    start = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      mon_step(ml, sclk_l, rck_l, busy_l, done_l, sout_l, ml);
      mon_step(mm, sclk_m, rck_m, busy_m, done_m, sout_m, mm);
      start = inj && (i == 10 || i == 12 || i == 14);
      if (inj && i == 10) data = d2;
    end
    start = 1'b0;
  endtask

  initial begin
    mon_t ml, mm, ma;
    bit   hit;

    vecs[0] = '{16'hC35A, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[1] = '{16'h0180, 8'h80, 8'h01, 8'h01, 8'h80};
    vecs[2] = '{16'hF00E, 8'h0E, 8'hF0, 8'h70, 8'h0F};
    vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[4] = '{16'h0000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{16'h2CB1, 8'hB1, 8'h2C, 8'h8D, 8'h34};

    reset = 1'b1; start = 1'b0; oe = 1'b0; data = '0; data_a = 16'hB00F;
    #1;
    chk("rst_sclk", sclk_l, 1'b0);
    chk("rst_rck", rck_l, 1'b0);
    chk("rst_en_n", en_n_l, 1'b1);
    chk("rst_sout", sout_l, 2'b00);
    chk("rst_busy", busy_l, 1'b0);
    chk("rst_done", done_l, 1'b0);
    chk("rst_auto_busy", busy_a, 1'b0);
    oe = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_en_n_held", en_n_l, 1'b1);
    oe = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      run_frame(vecs[k].data, 16'h0000, 1'b0, 45, ml, mm);
      chk($sformatf("v%0d_lsb_c0", k), ml.w0[7:0], vecs[k].l0);
      chk($sformatf("v%0d_lsb_c1", k), ml.w1[7:0], vecs[k].l1);
      chk($sformatf("v%0d_msb_c0", k), mm.w0[7:0], vecs[k].m0);
      chk($sformatf("v%0d_msb_c1", k), mm.w1[7:0], vecs[k].m1);
      chk($sformatf("v%0d_rises", k), ml.rises, 8);
      chk($sformatf("v%0d_rck", k), ml.rcks, 1);
      chk($sformatf("v%0d_busy", k), ml.busy, 34);
      chk($sformatf("v%0d_msb_busy", k), mm.busy, 34);
      chk($sformatf("v%0d_dones", k), ml.dones, 1);
      chk($sformatf("v%0d_done_cyc", k), ml.d1, 35);
      chk($sformatf("v%0d_rck_sclk", k), ml.viol, 0);
    end

    // Pending request merged; second frame carries the new data.
    run_frame(16'h1234, 16'hA5C3, 1'b1, 110, ml, mm);
    chk("pend_rises", ml.rises, 16);
    chk("pend_rck", ml.rcks, 2);
    chk("pend_dones", ml.dones, 2);
    chk("pend_busy", ml.busy, 68);
    chk("pend_gap", ml.gap, 1);
    chk("pend_done_iv", ml.d2 - ml.d1, 35);
    chk("pend_lsb_c0", ml.w0, 16'hC334);
    chk("pend_lsb_c1", ml.w1, 16'hA512);
    chk("pend_msb_c0", mm.w0, 16'hC32C);
    chk("pend_msb_c1", mm.w1, 16'hA548);

    // Reset after three sclk rises.
    oe = 1'b1;
    ml = mon_new();
    hit = 1'b0;
    @(negedge clk);
    data = 16'hC35A; start = 1'b1;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      mon_step(ml, sclk_l, rck_l, busy_l, done_l, sout_l, ml);
      start = 1'b0;
      if (ml.rises == 3) hit = 1'b1;
    end
    chk("mid_rises", ml.rises, 3);
    chk("mid_en_n_pre", en_n_l, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_sclk", sclk_l, 1'b0);
    chk("mid_rck", rck_l, 1'b0);
    chk("mid_sout", sout_l, 2'b00);
    chk("mid_busy", busy_l, 1'b0);
    chk("mid_en_n", en_n_l, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mon_step(ml, sclk_l, rck_l, busy_l, done_l, sout_l, ml);
    end
    chk("mid_no_rck", ml.rcks, 0);
    chk("mid_idle_rises", ml.rises, 3);
    oe = 1'b0;
    run_frame(16'hC35A, 16'h0000, 1'b0, 45, ml, mm);
    chk("post_rises", ml.rises, 8);
    chk("post_c0", ml.w0[7:0], 8'h5A);
    chk("post_c1", ml.w1[7:0], 8'hC3);
    chk("post_rck", ml.rcks, 1);

    // oe toggled during a frame.
    ml = mon_new();
    @(negedge clk);
    data = 16'h0180; start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      mon_step(ml, sclk_l, rck_l, busy_l, done_l, sout_l, ml);
      start = 1'b0;
      if (i == 5) begin
        oe = 1'b1;
        #1;
        chk("oe_lag", en_n_l, 1'b1);
      end
      if (i == 6) begin
        chk("oe_on", en_n_l, 1'b0);
        oe = 1'b0;
      end
      if (i == 7) chk("oe_off", en_n_l, 1'b1);
    end
    chk("oe_rises", ml.rises, 8);
    chk("oe_busy", ml.busy, 34);
    chk("oe_done_cyc", ml.d1, 35);
    chk("oe_c0", ml.w0[7:0], 8'h80);

    // Free-running instance from a fresh reset.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ma = mon_new();
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      mon_step(ma, sclk_a, rck_a, busy_a, done_a, {1'b0, sout_a}, ma);
    end
    chk("auto_busy_run", ma.run1, 33);
    chk("auto_d1", ma.d1, 34);
    chk("auto_period", ma.d2 - ma.d1, 34);
    chk("auto_gap", ma.gap, 1);
    chk("auto_word", ma.w0, 16'hB00F);
    chk("auto_rck_sclk", ma.viol, 0);
    chk("auto_rck", ma.rcks, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
